// File: rtl/uart_pkg.sv
// Shared UART constants (also used by the uart_tx/uart_rx benches) and the
// state encoding of the TX arbiter FSM.
package uart_pkg;

    localparam int SYS_CLOCK              = 50000000;
    localparam int UART_BAUDRATE          = 115200;
    localparam int DEFAULT_TIMEOUT_CYCLES = 8192;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping from NUM_REQ-1 back to 0. Grant is one-hot, idx_o its index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   idx_o,
    output logic               valid_o
);

    int k;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        k       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Explicit wrap so non-power-of-two NUM_REQ never overflows into unused slots.
            k = int'(ptr_i) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (!valid_o && req_i[k]) begin
                valid_o    = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = PTR_W'(k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between NUM_REQ byte producers.
// Optional watchdog on the uart_tx done: define UART_TX_ARBITER_TIMEOUT_EN.
//
// Handshake: a producer holds i_ReqValid[k] (with its byte) until o_ReqAck[k]
// pulses; the byte is captured at grant, so later changes or an early drop
// of valid do not affect the frame in flight. Toward uart_tx, o_TxValid is a
// single-cycle launch strobe and i_TxDone is only honoured in WAIT_DONE.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
`ifdef UART_TX_ARBITER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
    input  logic                 i_SysClock,
    input  logic                 i_Reset,
    input  logic [NUM_REQ-1:0]   i_ReqValid,
    input  logic [8*NUM_REQ-1:0] i_ReqByte,
    output logic [NUM_REQ-1:0]   o_ReqAck,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_Busy,
    output logic                 o_Timeout,
    output logic                 o_TxValid,
    output logic [7:0]           o_TxByte,
    input  logic                 i_TxDone,
    output logic [1:0]           o_DbgState
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_e           state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [7:0]           byte_q, byte_d;
    logic                 timeout_q, timeout_d;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [PTR_W-1:0]     arb_idx;
    logic                 arb_valid;

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    logic [15:0]          cnt_q, cnt_d;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req_i   (i_ReqValid),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        byte_d    = byte_q;
        ack_d     = '0;
        timeout_d = 1'b0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = LAUNCH;
                    grant_d = arb_grant;
                    byte_d  = i_ReqByte[8*arb_idx +: 8];
                    ptr_d   = (arb_idx == PTR_W'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
                end
            end
            LAUNCH: begin
                state_d = WAIT_DONE;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT_DONE: begin
                // A done that coincides with the watchdog limit wins: normal completion.
                if (i_TxDone) begin
                    ack_d   = grant_q;
                    grant_d = '0;
                    state_d = IDLE;
                end
`ifdef UART_TX_ARBITER_TIMEOUT_EN
                else if (cnt_q == 16'(TIMEOUT_CYCLES-1)) begin
                    ack_d     = grant_q;
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_SysClock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            ack_q     <= '0;
            byte_q    <= '0;
            timeout_q <= 1'b0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            byte_q    <= byte_d;
            timeout_q <= timeout_d;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

`ifndef UART_TX_ARBITER_TIMEOUT_EN
    // Without the watchdog timeout_d is constantly 0, so timeout_q stays at reset value.
`endif

    assign o_ReqAck   = ack_q;
    assign o_Grant    = grant_q;
    assign o_Busy     = (state_q != IDLE);
    assign o_Timeout  = timeout_q;
    assign o_TxValid  = (state_q == LAUNCH);
    assign o_TxByte   = byte_q;
    assign o_DbgState = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_v;
    logic [8*N-1:0] req_b;
    logic           tx_done;
    logic [N-1:0]   ack, grant;
    logic           busy, tmo, tx_valid;
    logic [7:0]     tx_byte;
    logic [1:0]     dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ(N)
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        , .TIMEOUT_CYCLES(64)
`endif
    ) dut (
        .i_SysClock (clk),
        .i_Reset    (rst),
        .i_ReqValid (req_v),
        .i_ReqByte  (req_b),
        .o_ReqAck   (ack),
        .o_Grant    (grant),
        .o_Busy     (busy),
        .o_Timeout  (tmo),
        .o_TxValid  (tx_valid),
        .o_TxByte   (tx_byte),
        .i_TxDone   (tx_done),
        .o_DbgState (dbg)
    );

    typedef struct {
        logic [N-1:0] req;
        int           win;
    } vec_t;

    vec_t vt[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic reset_dut();
        rst     = 1'b1;
        req_v   = '0;
        req_b   = '0;
        tx_done = 1'b0;
        tick();
        tick();
        chk("rst_ack", ack, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", tmo, 0);
        chk("rst_txvalid", tx_valid, 0);
        chk("rst_txbyte", tx_byte, 0);
        chk("rst_state", dbg, IDLE);
        rst = 1'b0;
    endtask

    // Serves one frame owned by requester w; uart_tx stand-in answers after two wait cycles.
    task automatic do_frame(input int w, input logic [7:0] b, input bit keep,
                            input bit solo, output int lat);
        int t;
        t = 0;
        while (tx_valid !== 1'b1 && t < 64) begin
            tick();
            t++;
        end
        lat = t;
        chk("launch_seen", tx_valid, 1);
        chk("grant", grant, 1 << w);
        chk("tx_byte", tx_byte, b);
        chk("busy", busy, 1);
        if (solo) req_v = req_v & N'(1 << w);
        tick();
        chk("txvalid_one_cycle", tx_valid, 0);
        tick();
        chk("grant_held", grant, 1 << w);
        chk("byte_held", tx_byte, b);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        if (!keep) req_v[w] = 1'b0;
        chk("ack", ack, 1 << w);
        chk("grant_drop", grant, 0);
        chk("timeout_low", tmo, 0);
    endtask

    task automatic run_table();
        int lat;
        vt[0]  = '{req: 4'b1111, win: 0};
        vt[1]  = '{req: 4'b1111, win: 1};
        vt[2]  = '{req: 4'b1101, win: 2};
        vt[3]  = '{req: 4'b1001, win: 3};
        vt[4]  = '{req: 4'b1001, win: 0};
        vt[5]  = '{req: 4'b0100, win: 2};
        vt[6]  = '{req: 4'b0011, win: 0};
        vt[7]  = '{req: 4'b0001, win: 0};
        vt[8]  = '{req: 4'b1000, win: 3};
        vt[9]  = '{req: 4'b0110, win: 1};
        vt[10] = '{req: 4'b0010, win: 1};
        vt[11] = '{req: 4'b1010, win: 3};
        reset_dut();
        for (int e = 0; e < 12; e++) begin
            for (int k = 0; k < N; k++) req_b[8*k +: 8] = {4'(e + 1), 4'(k)};
            req_v = vt[e].req;
            do_frame(vt[e].win, {4'(e + 1), 4'(vt[e].win)}, 1'b0, 1'b1, lat);
            chk("tbl_latency", lat, 1);
        end
    endtask

    task automatic run_hand();
        int lat;
        // All four at once from pointer 0: served in index order, back-to-back.
        reset_dut();
        req_b = {8'h44, 8'h33, 8'h22, 8'h11};
        req_v = 4'b1111;
        for (int i = 0; i < N; i++) begin
            do_frame(i, 8'(8'h11 * (i + 1)), 1'b0, 1'b0, lat);
            chk("sim_gap", lat, 1);
        end
        tick();
        chk("sim_idle", busy, 0);
        chk("sim_ack_single", ack, 0);

        // Single request from 2 moves pointer to 3, then 0 and 3 alternate.
        reset_dut();
        req_b[23:16] = 8'h55;
        req_v = 4'b0100;
        do_frame(2, 8'h55, 1'b0, 1'b0, lat);
        chk("single_latency", lat, 1);
        tick();
        chk("single_busy_after", busy, 0);
        chk("single_ack_once", ack, 0);
        req_b[7:0]   = 8'hA0;
        req_b[31:24] = 8'hA3;
        req_v = 4'b1001;
        do_frame(3, 8'hA3, 1'b1, 1'b0, lat);
        do_frame(0, 8'hA0, 1'b1, 1'b0, lat);
        chk("wrap_gap", lat, 1);
        do_frame(3, 8'hA3, 1'b1, 1'b0, lat);
        do_frame(0, 8'hA0, 1'b1, 1'b0, lat);
        req_v = '0;
        tick();
        chk("wrap_idle", busy, 0);

        // Requester 1 withdraws before ever winning; requester 0 alters its byte mid-frame.
        reset_dut();
        req_b[7:0]  = 8'hA5;
        req_b[15:8] = 8'h77;
        req_v = 4'b0011;
        tick();
        chk("wd_grant0", grant, 1);
        chk("wd_byte", tx_byte, 8'hA5);
        req_b[7:0] = 8'hFF;
        req_v[1]   = 1'b0;
        tick();
        tick();
        chk("wd_byte_latched", tx_byte, 8'hA5);
        tx_done = 1'b1;
        tick();
        tx_done  = 1'b0;
        req_v[0] = 1'b0;
        chk("wd_ack0", ack, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wd_never_granted", grant, 0);
        end

        // Reset while waiting for done: outputs clear without a clock edge, no ack.
        req_b[23:16] = 8'h99;
        req_v = 4'b0100;
        tick();
        tick();
        chk("mid_state", dbg, WAIT_DONE);
        rst = 1'b1;
        #1;
        chk("mid_grant", grant, 0);
        chk("mid_busy", busy, 0);
        chk("mid_byte", tx_byte, 0);
        chk("mid_txvalid", tx_valid, 0);
        tick();
        chk("mid_no_ack", ack, 0);
        rst = 1'b0;
        req_v = 4'b0010;
        req_b[15:8] = 8'h3C;
        do_frame(1, 8'h3C, 1'b0, 1'b0, lat);
        chk("mid_restart_latency", lat, 1);

        // Done while idle or during the launch cycle must not complete anything.
        tick();
        tx_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_done_no_ack", ack, 0);
            chk("idle_done_busy", busy, 0);
        end
        tx_done = 1'b0;
        req_v = 4'b0001;
        req_b[7:0] = 8'h42;
        tick();
        chk("launch_done_txvalid", tx_valid, 1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("launch_done_no_ack", ack, 0);
        tick();
        chk("launch_done_busy", busy, 1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        req_v = '0;
        chk("launch_done_real_ack", ack, 1);
        tick();
    endtask

    // Reference: a frame launches one cycle after an idle cycle with requests,
    // winner = first requester at/after the pointer; ack follows done by one cycle.
    task automatic run_random();
        bit             active;
        int             owner, launch_c, ptr_m, w, stub_cnt, frames;
        bit             idle_prev, exp_launch;
        logic [7:0]     mbyte;
        logic [N-1:0]   p_v, exp_ack, exp_grant;
        logic [8*N-1:0] p_b;
        logic           p_done;
        int             waitn[N];
        reset_dut();
        active = 0; owner = 0; launch_c = -10; ptr_m = 0; stub_cnt = 0; frames = 0;
        mbyte = '0; p_v = '0; p_b = '0; p_done = 1'b0;
        for (int k = 0; k < N; k++) waitn[k] = 0;
        for (int c = 1; c < 3000; c++) begin
            tick();
            exp_ack    = '0;
            exp_launch = 0;
            idle_prev  = !active;
            if (active && (c - 1) > launch_c && p_done) begin
                exp_ack = N'(1 << owner);
                active  = 0;
            end else if (idle_prev && p_v != 0) begin
                w = -1;
                for (int i = 0; i < N; i++) begin
                    int k;
                    k = (ptr_m + i) % N;
                    if (w < 0 && p_v[k]) w = k;
                end
                for (int k = 0; k < N; k++) begin
                    if (k != w && p_v[k]) begin
                        waitn[k]++;
                        chk("rnd_starvation", waitn[k] <= N - 1, 1);
                    end
                end
                waitn[w]   = 0;
                owner      = w;
                mbyte      = p_b[8*w +: 8];
                ptr_m      = (w + 1) % N;
                active     = 1;
                launch_c   = c;
                exp_launch = 1;
                frames++;
            end
            for (int k = 0; k < N; k++) if (!p_v[k]) waitn[k] = 0;
            exp_grant = active ? N'(1 << owner) : '0;
            chk("rnd_txvalid", tx_valid, exp_launch);
            chk("rnd_ack", ack, exp_ack);
            chk("rnd_grant", grant, exp_grant);
            chk("rnd_busy", busy, active);
            chk("rnd_timeout", tmo, 0);
            if (active) chk("rnd_txbyte", tx_byte, mbyte);

            if (exp_launch) begin
                stub_cnt = $urandom_range(1, 6);
                tx_done  = ($urandom_range(0, 3) == 0);
            end else if (active) begin
                stub_cnt--;
                tx_done = (stub_cnt == 0);
            end else begin
                tx_done = ($urandom_range(0, 7) == 0);
            end
            for (int k = 0; k < N; k++) begin
                if (exp_ack[k]) begin
                    req_v[k] = 1'($urandom_range(0, 1));
                    req_b[8*k +: 8] = 8'($urandom);
                end else if (active && owner == k) begin
                    if ($urandom_range(0, 3) == 0) req_b[8*k +: 8] = 8'($urandom);
                    if ($urandom_range(0, 7) == 0) req_v[k] = 1'b0;
                end else if (!req_v[k]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_v[k] = 1'b1;
                        req_b[8*k +: 8] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_v[k] = 1'b0;
                end
            end
            p_v    = req_v;
            p_b    = req_b;
            p_done = tx_done;
        end
        chk("rnd_frames_progress", frames > 100, 1);
        req_v   = '0;
        tx_done = 1'b0;
    endtask

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    task automatic run_timeout();
        int t;
        reset_dut();
        req_v = 4'b0001;
        req_b[7:0] = 8'h5A;
        tick();
        chk("to_launch", tx_valid, 1);
        t = 0;
        while (tmo !== 1'b1 && t < 200) begin
            tick();
            t++;
        end
        // 64 WAIT_DONE cycles elapse, the pulse lands on the following cycle.
        chk("to_cycles", t, 65);
        chk("to_ack", ack, 1);
        chk("to_grant", grant, 0);
        req_v = '0;
        tick();
        chk("to_pulse_width", tmo, 0);
        chk("to_idle", busy, 0);
    endtask
`endif

    initial begin
        run_table();
        run_hand();
        run_random();
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        run_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
